multiplex: RTL and testbench
============================

// Module: multiplex
// PURPOSE
//  Merges INC independent strobe/ready argument streams into one output stream with fair round-robin arbitration.
//  Emits the winning source index on a separate strobe/ready stream alongside each word.
//  A downstream demultiplex can route on that index stream, so it closes the fan-out/fan-in loop between units.
//  Single registered output slot; 1-cycle latency; one word per cycle sustained.
// PARAMETERS
//  ARGW  16  width of each argument word
//  INC   2   number of input streams; legal range INC >= 2, need not be a power of two
// PORTS
//  clk      in   1              single clock, rising edge
//  rst_n    in   1              asynchronous reset, active low
//  in_stb   in   INC            per-input word valid
//  in_dat   in   INC*ARGW       input i word at [ARGW*i +: ARGW]
//  in_rdy   out  INC            per-input accept; at most one bit high per cycle
//  out_stb  out  1              merged word valid (registered)
//  out_dat  out  ARGW           merged word (registered)
//  out_rdy  in   1              merged word consumer ready
//  idx_stb  out  1              source index valid (registered)
//  idx_dat  out  $clog2(INC)    index of the input that supplied the held word
//  idx_rdy  in   1              index consumer ready
// BEHAVIOUR
//  Reset: rst_n low clears state immediately, without waiting for a clock edge.
//   - out_stb=0, idx_stb=0, out_dat=0, idx_dat=0, ptr=0.
//   - Any held word is discarded.
//   - After release, arbitration restarts from input 0.
//  Handshake: a transfer occurs on a stream in any cycle where stb & rdy are both high.
//   - stb is never withdrawn before its transfer completes.
//   - Data is held stable while stb is high and rdy is low.
//  Slot free: free = (~out_stb | out_rdy) & (~idx_stb | idx_rdy).
//   - The slot may refill in the same cycle it drains (no bubble).
//  Grant (combinational): g is the first i with in_stb[i] high, searching cyclically ptr, ptr+1, ..., INC-1, 0, ..., ptr-1.
//  in_rdy[g] = free & in_stb[g]; all other in_rdy bits are 0.
//   - in_rdy depends on in_stb, the same as the sel/arg ready rule used by demultiplex.
//   - If no input is valid, in_rdy = 0.
//  Accept (posedge clk, when in_stb[g] & in_rdy[g]):
//   - out_dat <= in_dat[g]; idx_dat <= g; out_stb <= 1; idx_stb <= 1.
//   - ptr <= (g == INC-1) ? 0 : g+1, giving an explicit wrap for non-power-of-two INC.
//  No accept:
//   - out_stb <= out_stb & ~out_rdy.
//   - idx_stb <= idx_stb & ~idx_rdy.
//   - ptr, out_dat and idx_dat hold.
//  The out and idx streams drain independently.
//   - Either one may complete first; the other stays asserted until it is acked.
//   - No new word is accepted until both have completed, or both complete in the current cycle.
//  Latency: a word accepted at edge N is visible on out_dat/idx_dat after edge N.
//  Throughput: 1 word/cycle while out_rdy = idx_rdy = 1.
//  Fairness: with all inputs continuously valid, the grant order is 0,1,...,INC-1,0,...
//   - Any valid input waits at most INC-1 accepts.
//  Simultaneous events: drain and accept in the same cycle means the accept wins.
//   - Both stb stay 1 and the new data/index replace the old.
//  Width rule: idx_dat is exactly $clog2(INC) bits; g never exceeds INC-1.
// TESTING
//  1. INC=4: in_stb=4'b0100, in_dat[2]=16'hBEEF, out_rdy=idx_rdy=1
//     -> in_rdy=4'b0100; next cycle out_stb=1, out_dat=BEEF, idx_stb=1, idx_dat=2.
//  2. INC=4: all in_stb high for 8 cycles, consumers ready
//     -> idx_dat sequence 0,1,2,3,0,1,2,3; exactly one in_rdy bit high per cycle.
//  3. Word held with out_rdy=0 for 3 cycles -> out_stb/out_dat/idx_dat stable, in_rdy=0;
//     out_rdy=idx_rdy=1 -> next input is accepted in that same cycle.
//  4. idx_rdy=1, out_rdy=0 -> idx_stb falls after 1 cycle, out_stb held, in_rdy=0;
//     out_rdy=1 -> accept resumes.
//  5. INC=3: inputs 2 and 0 valid, ptr=2 -> grant 2, then 0 (wrap); idx_dat 2'd2 then 2'd0.
//  6. rst_n pulsed low between edges while a word is held -> out_stb=idx_stb=0 immediately;
//     after release, with inputs 1 and 0 valid, input 0 wins first.

Source files
------------

// File: rtl/multiplex.sv
// Round-robin merge of INC strobe/ready argument streams into one registered
// output word, with the winning source index on a parallel strobe/ready stream.
// The out and idx streams drain independently. A new word is accepted only
// when both streams are empty, or are draining in the current cycle.
module multiplex #(
  parameter int ARGW = 16,
  parameter int INC  = 2,
  localparam int IW  = $clog2(INC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INC-1:0]      in_stb,
  input  logic [INC*ARGW-1:0] in_dat,
  output logic [INC-1:0]      in_rdy,
  output logic                out_stb,
  output logic [ARGW-1:0]     out_dat,
  input  logic                out_rdy,
  output logic                idx_stb,
  output logic [IW-1:0]       idx_dat,
  input  logic                idx_rdy
);

  logic            out_stb_q, out_stb_d;
  logic [ARGW-1:0] out_dat_q, out_dat_d;
  logic            idx_stb_q, idx_stb_d;
  logic [IW-1:0]   idx_dat_q, idx_dat_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [IW-1:0]   gnt;
  logic            gnt_vld;
  logic            free;
  logic            accept;
  int              cand;

  // Cyclic priority search starting at ptr; the first valid input wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int k = 0; k < INC; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= INC) cand = cand - INC;
      if (!gnt_vld && in_stb[IW'(cand)]) begin
        gnt     = IW'(cand);
        gnt_vld = 1'b1;
      end
    end
  end

  // The slot is free when each stream is either empty or draining this cycle,
  // so it can refill in the same cycle it empties.
  always_comb begin
    free   = (~out_stb_q | out_rdy) & (~idx_stb_q | idx_rdy);
    accept = free & gnt_vld;
    in_rdy = '0;
    for (int i = 0; i < INC; i++) begin
      in_rdy[i] = accept && (gnt == IW'(i));
    end
  end

  // Next-state: an accept overrides a drain; otherwise each stream drains
  // on its own ack while the data, index and pointer hold.
  always_comb begin
    out_stb_d = out_stb_q & ~out_rdy;
    idx_stb_d = idx_stb_q & ~idx_rdy;
    out_dat_d = out_dat_q;
    idx_dat_d = idx_dat_q;
    ptr_d     = ptr_q;
    if (accept) begin
      out_stb_d = 1'b1;
      idx_stb_d = 1'b1;
      out_dat_d = in_dat[ARGW*gnt +: ARGW];
      idx_dat_d = gnt;
      // Explicit wrap so non-power-of-two INC never points past INC-1.
      ptr_d     = (gnt == IW'(INC-1)) ? '0 : gnt + IW'(1);
    end
  end

  // Output slot and arbitration pointer; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stb_q <= 1'b0;
      out_dat_q <= '0;
      idx_stb_q <= 1'b0;
      idx_dat_q <= '0;
      ptr_q     <= '0;
    end else begin
      out_stb_q <= out_stb_d;
      out_dat_q <= out_dat_d;
      idx_stb_q <= idx_stb_d;
      idx_dat_q <= idx_dat_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_stb = out_stb_q;
  assign out_dat = out_dat_q;
  assign idx_stb = idx_stb_q;
  assign idx_dat = idx_dat_q;

endmodule

// File: tb/tb_multiplex.sv
// Directed bench for multiplex: a 4-input and a 3-input instance
// driven from one linear sequence of steps.
module tb_multiplex;

  logic clk;
  logic rst_n;

  // INC=4 instance signals
  logic [3:0]  a4_stb;
  logic [63:0] a4_dat;
  logic [3:0]  a4_rdy;
  logic        a4_ostb;
  logic [15:0] a4_odat;
  logic        a4_ordy;
  logic        a4_istb;
  logic [1:0]  a4_idat;
  logic        a4_irdy;

  // INC=3 instance signals
  logic [2:0]  a3_stb;
  logic [47:0] a3_dat;
  logic [2:0]  a3_rdy;
  logic        a3_ostb;
  logic [15:0] a3_odat;
  logic        a3_ordy;
  logic        a3_istb;
  logic [1:0]  a3_idat;
  logic        a3_irdy;

  int n_chk;
  int n_err;

  multiplex #(.ARGW(16), .INC(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_stb(a4_stb), .in_dat(a4_dat), .in_rdy(a4_rdy),
    .out_stb(a4_ostb), .out_dat(a4_odat), .out_rdy(a4_ordy),
    .idx_stb(a4_istb), .idx_dat(a4_idat), .idx_rdy(a4_irdy)
  );

  multiplex #(.ARGW(16), .INC(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_stb(a3_stb), .in_dat(a3_dat), .in_rdy(a3_rdy),
    .out_stb(a3_ostb), .out_dat(a3_odat), .out_rdy(a3_ordy),
    .idx_stb(a3_istb), .idx_dat(a3_idat), .idx_rdy(a3_irdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    a4_stb  = '0; a4_dat = '0; a4_ordy = 1'b1; a4_irdy = 1'b1;
    a3_stb  = '0; a3_dat = '0; a3_ordy = 1'b1; a3_irdy = 1'b1;
    #12;
    chk("reset_out_stb", 64'(a4_ostb), 64'd0);
    chk("reset_idx_stb", 64'(a4_istb), 64'd0);
    chk("reset_out_dat", 64'(a4_odat), 64'd0);
    chk("reset_idx_dat", 64'(a4_idat), 64'd0);
    chk("reset_in_rdy",  64'(a4_rdy),  64'd0);
    rst_n = 1'b1;
    tick();

    // INC=3: walk ptr to 2, then inputs 2 and 0 valid -> grant 2 then wrap to 0
    a3_stb = 3'b001; a3_dat[0 +: 16] = 16'h3000;
    #1 chk("inc3_rdy_a", 64'(a3_rdy), 64'(3'b001));
    tick();
    a3_stb = 3'b010; a3_dat[16 +: 16] = 16'h3001;
    #1 chk("inc3_rdy_b", 64'(a3_rdy), 64'(3'b010));
    tick();
    a3_stb = 3'b101; a3_dat[32 +: 16] = 16'h3002;
    #1 chk("inc3_rdy_g2", 64'(a3_rdy), 64'(3'b100));
    tick();
    chk("inc3_idx_2", 64'(a3_idat), 64'd2);
    chk("inc3_dat_2", 64'(a3_odat), 64'h3002);
    chk("inc3_rdy_wrap", 64'(a3_rdy), 64'(3'b001));
    tick();
    chk("inc3_idx_0", 64'(a3_idat), 64'd0);
    chk("inc3_dat_0", 64'(a3_odat), 64'h3000);
    a3_stb = '0;
    tick();
    chk("inc3_drained", 64'({a3_ostb, a3_istb}), 64'd0);

    // INC=4: all inputs valid -> grants 0,1,2,3,0,1,2,3
    a4_stb = 4'b1111;
    for (int i = 0; i < 4; i++) a4_dat[16*i +: 16] = 16'h1000 + 16'(i);
    for (int c = 0; c < 8; c++) begin
      #1 chk($sformatf("rr_rdy_%0d", c), 64'(a4_rdy), 64'(4'b0001 << (c % 4)));
      tick();
      chk($sformatf("rr_idx_%0d", c), 64'(a4_idat), 64'(c % 4));
      chk($sformatf("rr_dat_%0d", c), 64'(a4_odat), 64'h1000 + 64'(c % 4));
    end

    // Single input 2 valid -> accepted immediately, visible after the edge
    a4_stb = 4'b0100; a4_dat[32 +: 16] = 16'hBEEF;
    #1 chk("one_rdy", 64'(a4_rdy), 64'(4'b0100));
    tick();
    chk("one_out_stb", 64'(a4_ostb), 64'd1);
    chk("one_out_dat", 64'(a4_odat), 64'hBEEF);
    chk("one_idx_stb", 64'(a4_istb), 64'd1);
    chk("one_idx_dat", 64'(a4_idat), 64'd2);

    // Stall both consumers for 3 cycles; word held, no accept
    a4_ordy = 1'b0; a4_irdy = 1'b0;
    a4_stb = 4'b0001; a4_dat[0 +: 16] = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("hold_rdy_%0d", c), 64'(a4_rdy), 64'd0);
      tick();
      chk($sformatf("hold_stb_%0d", c), 64'({a4_ostb, a4_istb}), 64'd3);
      chk($sformatf("hold_dat_%0d", c), 64'(a4_odat), 64'hBEEF);
      chk($sformatf("hold_idx_%0d", c), 64'(a4_idat), 64'd2);
    end
    a4_ordy = 1'b1; a4_irdy = 1'b1;
    #1 chk("refill_rdy", 64'(a4_rdy), 64'(4'b0001));
    tick();
    chk("refill_dat", 64'(a4_odat), 64'h1111);
    chk("refill_idx", 64'(a4_idat), 64'd0);
    chk("refill_stb", 64'({a4_ostb, a4_istb}), 64'd3);

    // idx drains while out stalls; no accept until out also drains
    a4_ordy = 1'b0; a4_irdy = 1'b1;
    a4_stb = 4'b0010; a4_dat[16 +: 16] = 16'h2222;
    #1 chk("split_rdy_a", 64'(a4_rdy), 64'd0);
    tick();
    chk("split_idx_stb", 64'(a4_istb), 64'd0);
    chk("split_out_stb", 64'(a4_ostb), 64'd1);
    chk("split_out_dat", 64'(a4_odat), 64'h1111);
    chk("split_rdy_b", 64'(a4_rdy), 64'd0);
    a4_ordy = 1'b1;
    #1 chk("split_rdy_c", 64'(a4_rdy), 64'(4'b0010));
    tick();
    chk("split_dat", 64'(a4_odat), 64'h2222);
    chk("split_idx", 64'(a4_idat), 64'd1);
    chk("split_stb", 64'({a4_ostb, a4_istb}), 64'd3);

    // Asynchronous reset mid-cycle while a word is held
    a4_stb = '0;
    a4_ordy = 1'b0; a4_irdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("areset_stb", 64'({a4_ostb, a4_istb}), 64'd0);
    chk("areset_dat", 64'(a4_odat), 64'd0);
    chk("areset_idx", 64'(a4_idat), 64'd0);
    rst_n = 1'b1;
    a4_ordy = 1'b1; a4_irdy = 1'b1;
    a4_stb = 4'b0011; a4_dat[0 +: 16] = 16'hA0A0; a4_dat[16 +: 16] = 16'hA1A1;
    #1 chk("post_rst_rdy", 64'(a4_rdy), 64'(4'b0001));
    tick();
    chk("post_rst_idx", 64'(a4_idat), 64'd0);
    chk("post_rst_dat", 64'(a4_odat), 64'hA0A0);
    chk("post_rst_rdy2", 64'(a4_rdy), 64'(4'b0010));
    tick();
    chk("post_rst_idx2", 64'(a4_idat), 64'd1);
    chk("post_rst_dat2", 64'(a4_odat), 64'hA1A1);
    a4_stb = '0;
    tick();
    chk("final_drain", 64'({a4_ostb, a4_istb}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
